r_station: RTL
==============

Name: r_station

Overview:
- Issue stage directly upstream of the register file. Buffers decoded micro-ops from the decoder in a small in-order queue.
- Presents the head op's read addresses and PC to the register file.
- Carries the issued op one cycle further, so that `dest_*` write-back control and the ALU opcode line up with the cycle in which the ALU consumes the latched operands.
- Because of that alignment, the register file's `dest_r_addr` forwarding compare always sees the op currently in the ALU.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- OP_W, 4, ALU opcode width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  decoder offers a micro-op.
- in_ready  out  1  queue can accept; equals (count != DEPTH).
- in_a  in  3  operand A register address; 3'b011 selects PC.
- in_b  in  3  operand B register address; 3'b011 selects PC.
- in_dest  in  2  destination register.
- in_wr  in  1  op writes in_dest.
- in_wf  in  1  op writes flags.
- in_op  in  OP_W  ALU opcode.
- in_pc  in  16  PC of the op.
- hold  in  1  downstream stall (memory/rmw); blocks issue.
- flush  in  1  discard all queued and in-flight ops.
- r_a_addr  out  3  head entry A address.
- r_b_addr  out  3  head entry B address.
- r_pc  out  16  head entry PC.
- alu_valid  out  1  ALU stage holds a real op.
- alu_op  out  OP_W  ALU-stage opcode.
- dest_r_wr  out  1  alu_valid & ALU-stage wr bit.
- dest_r_addr  out  2  ALU-stage destination.
- dest_w_flags  out  1  alu_valid & ALU-stage wf bit.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async, rst_n=0): all of the following clear immediately and hold until rst_n rises:
  - read/write pointers and count = 0;
  - all entry storage = 0;
  - ALU-stage registers = 0 (alu_valid=0, alu_op=0, dest_r_wr=0, dest_r_addr=0, dest_w_flags=0).
  - With count = 0, in_ready = 1.
- Enqueue: `enq = in_valid & in_ready & ~flush`.
  - The entry is written at the tail; the tail pointer increments modulo DEPTH.
- Issue: `iss = (count != 0) & ~hold & ~flush`.
  - r_a_addr, r_b_addr and r_pc are combinational from the head entry, so they are valid in the issue cycle N.
  - On the edge ending cycle N, the head pointer increments.
  - On that same edge, the head's op/dest/wr/wf are loaded into the ALU-stage registers with alu_valid=1.
  - Those outputs are therefore visible in cycle N+1, when the register file's latched operands are on alu_a/alu_b.
- Empty or hold: at the next edge, alu_valid=0, dest_r_wr=0, dest_w_flags=0 (bubble).
  - alu_op and dest_r_addr keep their last value.
  - While count=0, r_* show the stale head slot; this is don't-care and not checked.
- Occupancy: count updates as count + enq - iss.
  - enq and iss in the same cycle leave count unchanged, including at count=DEPTH-1.
  - At count=DEPTH, in_ready=0 even if iss is high that cycle; there is no combinational ready-through path.
- Flush: highest priority, overrides enq and iss.
  - On the next edge, pointers and count = 0, and alu_valid, dest_r_wr, dest_w_flags = 0.
  - Storage contents are not cleared.
- hold and flush together: flush wins.
- hold does not freeze the ALU stage. The op already in the ALU stage completes its write-back control in the current cycle; the stage then becomes a bubble.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is resolved by count, not by pointer compare.
- Ordering: strictly in order. There is no scoreboard; read-after-write on the immediately preceding op is resolved by register-file forwarding from dest_r_addr.
- No X on any output after reset.

Decomposition:
- Package r_station_pkg holds:
  - REG_PC = 3'b011;
  - field widths (REG_AW=3, DEST_W=2, PC_W=16);
  - packed typedef uop_t {a, b, dest, wr, wf, op, pc}.
- One sub-module, uop_fifo: a parameterised DEPTH x uop_t circular buffer with count, head-data output, and synchronous flush.
- r_station wraps uop_fifo plus the ALU-stage register and the issue logic.

Test Plan:
- Reset then single op (a=1, b=2, dest=1, wr=1, op=4'h3, pc=16'h0100) with no hold:
  - cycle 0 (enqueue edge): op accepted.
  - cycle 1 (issue cycle): r_a_addr=1, r_b_addr=2, r_pc=16'h0100.
  - cycle 2: alu_valid=1, alu_op=3, dest_r_wr=1, dest_r_addr=1.
  - cycle 3: alu_valid=0.
- Back-to-back dependent pair (op1 writes dest=2; op2 reads a=2):
  - dest_r_addr=2 with dest_r_wr=1 in the same cycle that r_a_addr=2 is presented.
  - This proves forwarding alignment.
- Fill 4 ops with hold=1:
  - count=4, in_ready=0, and a 5th in_valid is not accepted.
  - Release hold: ops issue in order on 4 consecutive cycles; count goes 4,3,2,1,0.
- Continuous enqueue+issue at count=3:
  - count stays 3 for 10 cycles; issue order matches enqueue order across pointer wrap.
- Flush asserted with count=3 and alu_valid=1, while in_valid=1:
  - next cycle count=0 and alu_valid=0; the flushed-cycle input is not enqueued.
- rst_n dropped mid-stream with count=2:
  - outputs clear asynchronously, before the next clk edge.
  - after release, in_ready=1 and count=0.

Source files
------------

// File: rtl/r_station_pkg.sv
// Shared widths and the decoded micro-op record carried through the issue queue.
package r_station_pkg;
    localparam int REG_AW   = 3;
    localparam int DEST_W   = 2;
    localparam int PC_W     = 16;
    localparam int UOP_OP_W = 4;
    localparam logic [REG_AW-1:0] REG_PC = 3'b011;

    typedef struct packed {
        logic [REG_AW-1:0]   a;
        logic [REG_AW-1:0]   b;
        logic [DEST_W-1:0]   dest;
        logic                wr;
        logic                wf;
        logic [UOP_OP_W-1:0] op;
        logic [PC_W-1:0]     pc;
    } uop_t;
endpackage

// File: rtl/r_station_if.sv
// Decoder-side, register-file-side and ALU-stage signals of the issue station.
interface r_station_if #(
    parameter int DEPTH = 4,
    parameter int OP_W  = 4
);
    import r_station_pkg::*;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_a;
    logic [REG_AW-1:0] in_b;
    logic [DEST_W-1:0] in_dest;
    logic              in_wr;
    logic              in_wf;
    logic [OP_W-1:0]   in_op;
    logic [PC_W-1:0]   in_pc;
    logic              hold;
    logic              flush;
    logic [REG_AW-1:0] r_a_addr;
    logic [REG_AW-1:0] r_b_addr;
    logic [PC_W-1:0]   r_pc;
    logic              alu_valid;
    logic [OP_W-1:0]   alu_op;
    logic              dest_r_wr;
    logic [DEST_W-1:0] dest_r_addr;
    logic              dest_w_flags;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_a, in_b, in_dest, in_wr, in_wf, in_op, in_pc, hold, flush,
        input  in_ready, r_a_addr, r_b_addr, r_pc, alu_valid, alu_op,
               dest_r_wr, dest_r_addr, dest_w_flags, count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_dest, in_wr, in_wf, in_op, in_pc, hold, flush,
        output in_ready, r_a_addr, r_b_addr, r_pc, alu_valid, alu_op,
               dest_r_wr, dest_r_addr, dest_w_flags, count
    );
endinterface

// File: rtl/r_station_fifo.sv
// Circular buffer of micro-ops; full/empty come from the occupancy count, not pointer compare.
module uop_fifo
    import r_station_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  uop_t                   i_data,
    input  logic                   i_pop,
    output uop_t                   o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    uop_t          r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;

    // Flush only rewinds pointers; stale entries are unreachable once count is zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= r_wp + AW'(1);
            end
            if (i_pop) r_rp <= r_rp + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rp];
    assign o_count = r_count;
endmodule

// File: rtl/r_station.sv
// Issue station: in-order uop queue feeding the register file, plus one ALU-aligned stage.
module r_station
    import r_station_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OP_W  = UOP_OP_W
) (
    input logic        clk,
    input logic        rst_n,
    r_station_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              w_full;
    logic              w_enq;
    logic              w_iss;
    logic [CNT_W-1:0]  w_count;
    uop_t              w_in_uop;
    uop_t              w_head;

    logic              r_alu_valid;
    logic [OP_W-1:0]   r_alu_op;
    logic [DEST_W-1:0] r_alu_dest;
    logic              r_alu_wr;
    logic              r_alu_wf;

    // Ready comes only from registered occupancy, so a full queue never accepts even while issuing.
    assign w_full       = (w_count == CNT_W'(DEPTH));
    assign bus.in_ready = ~w_full;
    assign w_enq        = bus.in_valid & ~w_full & ~bus.flush;
    assign w_iss        = (w_count != '0) & ~bus.hold & ~bus.flush;

    assign w_in_uop = '{a: bus.in_a, b: bus.in_b, dest: bus.in_dest, wr: bus.in_wr,
                        wf: bus.in_wf, op: UOP_OP_W'(bus.in_op), pc: bus.in_pc};

    uop_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.flush),
        .i_push  (w_enq),
        .i_data  (w_in_uop),
        .i_pop   (w_iss),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.r_a_addr = w_head.a;
    assign bus.r_b_addr = w_head.b;
    assign bus.r_pc     = w_head.pc;
    assign bus.count    = w_count;

    // Hold, flush and empty all become a bubble; op/dest keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_valid <= 1'b0;
            r_alu_op    <= '0;
            r_alu_dest  <= '0;
            r_alu_wr    <= 1'b0;
            r_alu_wf    <= 1'b0;
        end else if (w_iss) begin
            r_alu_valid <= 1'b1;
            r_alu_op    <= OP_W'(w_head.op);
            r_alu_dest  <= w_head.dest;
            r_alu_wr    <= w_head.wr;
            r_alu_wf    <= w_head.wf;
        end else begin
            r_alu_valid <= 1'b0;
            r_alu_wr    <= 1'b0;
            r_alu_wf    <= 1'b0;
        end
    end

    assign bus.alu_valid    = r_alu_valid;
    assign bus.alu_op       = r_alu_op;
    assign bus.dest_r_addr  = r_alu_dest;
    assign bus.dest_r_wr    = r_alu_valid & r_alu_wr;
    assign bus.dest_w_flags = r_alu_valid & r_alu_wf;
endmodule
